viterbi_decoder_k3: RTL and testbench

VITERBI_DECODER_K3 -- requirements
Module: viterbi_decoder_k3

---
 rtl/viterbi_decoder_k3.sv | 135 +++++++++++++
 tb/tb_viterbi_decoder_k3.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_decoder_k3.sv
// Hard-decision Viterbi decoder, K=3 rate 1/2 (generators 111/101), register-exchange survivors.
// Define VITERBI_PM_NORM_EN to subtract the minimum path metric each step; otherwise metrics saturate.
module viterbi_decoder_k3 #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              encoded1,
  input  logic              encoded2,
  input  logic              in_valid,
  output logic              decoded_bit,
  output logic              out_valid,
  output logic [4*PM_W-1:0] pm_dbg_o
);

  // Handshake: a symbol is consumed on every rising edge with in_valid=1 (no backpressure);
  // out_valid is a one-cycle qualifier for decoded_bit, which holds its value otherwise.

  localparam int FW = $clog2(TB_DEPTH + 1);
`ifndef VITERBI_PM_NORM_EN
  localparam logic [PM_W:0] PM_SAT = {1'b0, {PM_W{1'b1}}};
`endif

  logic [PM_W-1:0]     pm_q   [4];
  logic [PM_W-1:0]     pm_d   [4];
  logic [TB_DEPTH-1:0] surv_q [4];
  logic [TB_DEPTH-1:0] surv_d [4];
  logic [TB_DEPTH-1:0] surv_acs [4];
  logic [PM_W:0]       pm_acs [4];
  logic [1:0]          best;
  logic [PM_W:0]       best_pm;
  logic [FW-1:0]       fill_q, fill_d;
  logic                dec_q, dec_d;
  logic                ov_q, ov_d;

  // Cost of reaching a next state from predecessor pred with input bit b.
  function automatic logic [PM_W:0] branch_cost(input logic [PM_W-1:0] pm,
                                                 input logic [1:0]      pred,
                                                 input logic            b,
                                                 input logic            e1,
                                                 input logic            e2);
    logic          o1, o2;
    logic [PM_W:0] sum;
    o1  = b ^ pred[1] ^ pred[0];
    o2  = b ^ pred[0];
    sum = {1'b0, pm} + {{PM_W{1'b0}}, e1 ^ o1} + {{PM_W{1'b0}}, e2 ^ o2};
`ifndef VITERBI_PM_NORM_EN
    if (sum > PM_SAT) sum = PM_SAT;
`endif
    return sum;
  endfunction

  always_comb begin : acs
    logic [1:0]    st, p0, p1;
    logic [PM_W:0] c0, c1;
    logic          sel;
    st  = '0;
    p0  = '0;
    p1  = '0;
    c0  = '0;
    c1  = '0;
    sel = 1'b0;
    for (int ns = 0; ns < 4; ns++) begin
      st  = 2'(ns);
      p0  = {st[0], 1'b0};
      p1  = {st[0], 1'b1};
      c0  = branch_cost(pm_q[p0], p0, st[1], encoded1, encoded2);
      c1  = branch_cost(pm_q[p1], p1, st[1], encoded1, encoded2);
      // Strict compare so a tie keeps the s2=0 predecessor.
      sel = (c1 < c0);
      pm_acs[ns]   = sel ? c1 : c0;
      surv_acs[ns] = {(sel ? surv_q[p1][TB_DEPTH-2:0] : surv_q[p0][TB_DEPTH-2:0]), st[1]};
    end
  end

  always_comb begin : best_search
    best    = 2'd0;
    best_pm = pm_acs[0];
    for (int i = 1; i < 4; i++) begin
      if (pm_acs[i] < best_pm) begin
        best    = 2'(i);
        best_pm = pm_acs[i];
      end
    end
  end

  always_comb begin : next_state
    pm_d   = pm_q;
    surv_d = surv_q;
    fill_d = fill_q;
    dec_d  = dec_q;
    ov_d   = 1'b0;
    if (in_valid) begin
      for (int i = 0; i < 4; i++) begin
`ifdef VITERBI_PM_NORM_EN
        pm_d[i] = PM_W'(pm_acs[i] - best_pm);
`else
        pm_d[i] = pm_acs[i][PM_W-1:0];
`endif
      end
      surv_d = surv_acs;
      dec_d  = surv_acs[best][TB_DEPTH-1];
      ov_d   = (fill_q >= FW'(TB_DEPTH - 1));
      if (fill_q < FW'(TB_DEPTH)) fill_d = fill_q + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm_q[0]   <= '0;
      pm_q[1]   <= PM_W'(4);
      pm_q[2]   <= PM_W'(4);
      pm_q[3]   <= PM_W'(4);
      surv_q[0] <= '0;
      surv_q[1] <= '0;
      surv_q[2] <= '0;
      surv_q[3] <= '0;
      fill_q    <= '0;
      dec_q     <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      pm_q   <= pm_d;
      surv_q <= surv_d;
      fill_q <= fill_d;
      dec_q  <= dec_d;
      ov_q   <= ov_d;
    end
  end

  assign decoded_bit = dec_q;
  assign out_valid   = ov_q;
  assign pm_dbg_o    = {pm_q[3], pm_q[2], pm_q[1], pm_q[0]};

endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// Bench for viterbi_decoder_k3: encodes random/directed data, injects sparse errors and gaps,
// and expects the transmitted data back through a scoreboard queue.
module tb_viterbi_decoder_k3;

  localparam int TB_DEPTH = 16;
  localparam int PM_W     = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              encoded1 = 1'b0;
  logic              encoded2 = 1'b0;
  logic              in_valid = 1'b0;
  logic              decoded_bit;
  logic              out_valid;
  logic [4*PM_W-1:0] pm_dbg;

  logic [0:0] exp_q[$];
  logic       stim_d[$];
  logic [1:0] stim_err[$];

  int n_checks = 0;
  int n_pass   = 0;

  viterbi_decoder_k3 #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .encoded1   (encoded1),
    .encoded2   (encoded2),
    .in_valid   (in_valid),
    .decoded_bit(decoded_bit),
    .out_valid  (out_valid),
    .pm_dbg_o   (pm_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
  endtask

  // monitor: expected out_valid from the accepted-symbol index since reset
  int   acc_idx  = 0;
  bit   e_ov     = 1'b0;
  logic last_bit = 1'b0;
  logic [0:0] eb;

  always @(posedge clk) begin
    if (!rst) begin
      acc_idx  = 0;
      e_ov     = 1'b0;
      last_bit = 1'b0;
    end else if (in_valid) begin
      e_ov = (acc_idx >= TB_DEPTH - 1);
      acc_idx++;
    end else begin
      e_ov = 1'b0;
    end
    #1;
    check(out_valid === e_ov, "out_valid", int'(out_valid), int'(e_ov));
    if (e_ov) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "scoreboard_underflow", 0, 1);
      end else begin
        eb = exp_q.pop_front();
        check(decoded_bit === eb[0], "decoded_bit", int'(decoded_bit), int'(eb[0]));
        last_bit = eb[0];
      end
    end else begin
      check(decoded_bit === last_bit, "decoded_bit_hold", int'(decoded_bit), int'(last_bit));
    end
`ifdef VITERBI_PM_NORM_EN
    for (int i = 0; i < 4; i++)
      check(pm_dbg[i*PM_W +: PM_W] <= PM_W'(4), "pm_bound", int'(pm_dbg[i*PM_W +: PM_W]), 4);
`endif
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      encoded1 = 1'($urandom_range(0, 1));
      encoded2 = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      encoded1 = 1'($urandom_range(0, 1));
      encoded2 = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic drive_sym(input logic e1, input logic e2, input logic d, input int gap);
    @(negedge clk);
    encoded1 = e1;
    encoded2 = e2;
    in_valid = 1'b1;
    exp_q.push_back(d);
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      encoded1 = 1'($urandom_range(0, 1));
      encoded2 = 1'($urandom_range(0, 1));
    end
  endtask

  // Reference encoder: the code's rule applied to the bit history, errors XORed on top.
  task automatic play(input int n_sym, input int min_gap, input int max_gap);
    logic s1, s2, b, o1, o2;
    s1 = 1'b0;
    s2 = 1'b0;
    for (int i = 0; i < n_sym && i < stim_d.size(); i++) begin
      b  = stim_d[i];
      o1 = b ^ s1 ^ s2;
      o2 = b ^ s2;
      drive_sym(o1 ^ stim_err[i][1], o2 ^ stim_err[i][0], b, $urandom_range(max_gap, min_gap));
      s2 = s1;
      s1 = b;
    end
  endtask

  task automatic end_stream();
    idle(4);
    check(exp_q.size() == TB_DEPTH - 1, "tail_count", exp_q.size(), TB_DEPTH - 1);
    exp_q.delete();
  endtask

  task automatic load_ref();
    logic [6:0] head;
    head = 7'b1110100;
    stim_d.delete();
    stim_err.delete();
    for (int i = 0; i < 7; i++) begin
      stim_d.push_back(head[6-i]);
      stim_err.push_back(2'b00);
    end
    for (int i = 0; i < 16; i++) begin
      stim_d.push_back(1'b0);
      stim_err.push_back(2'b00);
    end
  endtask

  initial begin
    int len, next_err;
    // reset with random activity, then quiet after release
    do_reset(20);
    idle(10);

    // clean reference stream, back-to-back
    load_ref();
    play(stim_d.size(), 0, 0);
    end_stream();

    // single error: third symbol 10 -> 11
    do_reset(2);
    load_ref();
    stim_err[2] = 2'b01;
    play(stim_d.size(), 0, 0);
    end_stream();

    // gapped input
    do_reset(2);
    load_ref();
    play(stim_d.size(), 1, 3);
    end_stream();

    // reset mid-stream, then replay
    do_reset(2);
    load_ref();
    play(10, 0, 0);
    do_reset(3);
    play(stim_d.size(), 0, 0);
    end_stream();

    // random data, sparse random errors, random gaps
    for (int it = 0; it < 6; it++) begin
      do_reset(2);
      stim_d.delete();
      stim_err.delete();
      len      = $urandom_range(60, 20);
      next_err = $urandom_range(15, 5);
      for (int i = 0; i < len; i++) begin
        stim_d.push_back(1'($urandom_range(0, 1)));
        if (i == next_err) begin
          stim_err.push_back(($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
          next_err = i + 12 + $urandom_range(8, 0);
        end else begin
          stim_err.push_back(2'b00);
        end
      end
      play(len, 0, 2);
      end_stream();
    end

    // long zero-data run with one error every 8 symbols
    do_reset(2);
    stim_d.delete();
    stim_err.delete();
    for (int i = 0; i < 1000; i++) begin
      stim_d.push_back(1'b0);
      if (i % 8 == 7) stim_err.push_back(((i / 8) % 2 == 1) ? 2'b01 : 2'b10);
      else stim_err.push_back(2'b00);
    end
    play(1000, 0, 0);
    end_stream();

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
